// File: rtl/adc_capture.sv
// adc_capture: front end for a parallel offset-binary ADC.
// Provides a live sample register, block averaging, and a level-triggered
// burst capture into a dual-port buffer that the processor reads back.
// It also keeps a saturating count of out-of-range cycles.
module adc_capture #(
    parameter int DATA_W     = 14,
    parameter int AVG_LOG2   = 4,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [7:0]            i_control,
    input  logic [DATA_W-1:0]     i_adc_data,
    input  logic                  i_adc_otr,
    input  logic [DATA_W-1:0]     i_trig_level,
    input  logic [DEPTH_LOG2-1:0] i_rd_addr,
    output logic                  o_adc_clk,
    output logic [DATA_W-1:0]     o_sample,
    output logic                  o_sample_valid,
    output logic [DATA_W-1:0]     o_rd_data,
    output logic                  o_capture_done,
    output logic [15:0]           o_otr_count
);

    localparam int ACC_W = DATA_W + AVG_LOG2;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DATA_W-1:0] MIDSCALE = {1'b0, {(DATA_W-1){1'b1}}};

    typedef enum logic [2:0] {
        S_IDLE, S_LIVE, S_AVG, S_ARM, S_CAPT, S_DONE
    } state_t;

    state_t                r_state, w_next;
    logic [DATA_W-1:0]     r_adc_q, r_adc_p;
    logic                  r_otr_q;
    logic [ACC_W-1:0]      r_acc;
    logic [AVG_LOG2-1:0]   r_cnt;
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic                  r_prev_valid;
    logic [DATA_W-1:0]     r_sample;
    logic                  r_sample_valid;
    logic                  r_capture_done;
    logic [15:0]           r_otr_count;
    logic [DATA_W-1:0]     r_rd_data;
    logic [DATA_W-1:0]     r_mem [0:DEPTH-1];

    logic [ACC_W-1:0]      w_acc_sum;
    logic                  w_blk_end, w_trig;
    logic                  w_ld_sample, w_acc_clr, w_acc_add;
    logic                  w_arm_clr, w_set_pv, w_we, w_done_set, w_otr_clr;
    logic [DATA_W-1:0]     w_sample_d;
    logic [DEPTH_LOG2-1:0] w_waddr;

    // Truncating divide of a full block sum by the block length.
    function automatic logic [DATA_W-1:0] avg_trunc(input logic [ACC_W-1:0] sum);
        return sum[ACC_W-1:AVG_LOG2];
    endfunction

    assign o_adc_clk = i_clk;
    assign w_acc_sum = r_acc + {{AVG_LOG2{1'b0}}, r_adc_q};
    assign w_blk_end = &r_cnt;
    assign w_trig    = r_prev_valid && (r_adc_p < i_trig_level) && (r_adc_q >= i_trig_level);

    // Input stage: raw ADC word and its one-cycle-older copy for edge detection.
    always_ff @(posedge i_clk) begin
        r_adc_q <= i_adc_data;
        r_adc_p <= r_adc_q;
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Next-state logic and per-cycle datapath strobes; any control change leaves via IDLE.
    always_comb begin
        w_next      = r_state;
        w_ld_sample = 1'b0;
        w_sample_d  = r_sample;
        w_acc_clr   = 1'b0;
        w_acc_add   = 1'b0;
        w_arm_clr   = 1'b0;
        w_set_pv    = 1'b0;
        w_we        = 1'b0;
        w_waddr     = r_wr_ptr;
        w_done_set  = 1'b0;
        w_otr_clr   = 1'b0;
        case (r_state)
            S_IDLE: begin
                case (i_control)
                    8'd0: w_next = S_LIVE;
                    8'd1: begin w_next = S_AVG; w_acc_clr = 1'b1; end
                    8'd2: begin w_next = S_ARM; w_arm_clr = 1'b1; end
                    8'd3: w_otr_clr = 1'b1;
                    default: w_next = S_IDLE;
                endcase
            end
            S_LIVE: begin
                if (i_control != 8'd0) w_next = S_IDLE;
                else begin
                    w_ld_sample = 1'b1;
                    w_sample_d  = r_adc_q;
                end
            end
            S_AVG: begin
                if (i_control != 8'd1) w_next = S_IDLE;
                else if (w_blk_end) begin
                    w_ld_sample = 1'b1;
                    w_sample_d  = avg_trunc(w_acc_sum);
                    w_acc_clr   = 1'b1;
                end else begin
                    w_acc_add = 1'b1;
                end
            end
            S_ARM: begin
                if (i_control != 8'd2) w_next = S_IDLE;
                else begin
                    w_set_pv = 1'b1;
                    if (w_trig) begin
                        w_we    = 1'b1;
                        w_waddr = '0;
                        w_next  = S_CAPT;
                    end
                end
            end
            S_CAPT: begin
                if (i_control != 8'd2) w_next = S_IDLE;
                else begin
                    w_we = 1'b1;
                    if (&r_wr_ptr) begin
                        w_next     = S_DONE;
                        w_done_set = 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (i_control != 8'd2) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Sample output, accumulator, capture pointer, done flag and OTR counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sample       <= MIDSCALE;
            r_sample_valid <= 1'b0;
            r_acc          <= '0;
            r_cnt          <= '0;
            r_wr_ptr       <= '0;
            r_prev_valid   <= 1'b0;
            r_capture_done <= 1'b0;
            r_otr_q        <= 1'b0;
            r_otr_count    <= '0;
        end else begin
            r_otr_q        <= i_adc_otr;
            r_sample_valid <= w_ld_sample;
            if (w_ld_sample) r_sample <= w_sample_d;
            if (w_acc_clr) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else if (w_acc_add) begin
                r_acc <= w_acc_sum;
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_arm_clr) begin
                r_wr_ptr       <= '0;
                r_capture_done <= 1'b0;
                r_prev_valid   <= 1'b0;
            end else begin
                if (w_set_pv)   r_prev_valid   <= 1'b1;
                if (w_we)       r_wr_ptr       <= w_waddr + 1'b1;
                if (w_done_set) r_capture_done <= 1'b1;
            end
            if (w_otr_clr)                      r_otr_count <= '0;
            else if (r_otr_q && !(&r_otr_count)) r_otr_count <= r_otr_count + 1'b1;
        end
    end

    // Simple dual-port buffer; a same-address read during a write returns old data.
    always_ff @(posedge i_clk) begin
        if (w_we) r_mem[w_waddr] <= r_adc_q;
        r_rd_data <= r_mem[i_rd_addr];
    end

    assign o_sample       = r_sample;
    assign o_sample_valid = r_sample_valid;
    assign o_rd_data      = r_rd_data;
    assign o_capture_done = r_capture_done;
    assign o_otr_count    = r_otr_count;

endmodule

// File: doc/adc_capture.md
Name: adc_capture

Overview:
- Receive-side counterpart of the 14-bit parallel DAC driver: captures samples from a parallel offset-binary ADC clocked by the fabric clock.
- Modes are selected by the same 8-bit control byte convention the DAC driver uses:
  - live sample register;
  - block averaging;
  - level-triggered burst capture into an on-chip buffer, read back by the processor.
- Sits between the ADC pins and the AXI register/readback logic of the lab IP.

Parameters:
DATA_W, 14, ADC sample width (unsigned offset-binary, midscale 2^(DATA_W-1)-1).
AVG_LOG2, 4, log2 of samples per average block.
DEPTH_LOG2, 10, log2 of burst buffer depth (DEPTH = 1024).

Ports:
clk  in  1  fabric clock; ADC sampled on rising edge.
rst_n  in  1  asynchronous reset, active low.
control  in  8  mode: 0 live, 1 average, 2 armed burst, 3 clear OTR counter, others idle.
adc_data  in  DATA_W  ADC parallel output.
adc_otr  in  1  ADC out-of-range flag.
trig_level  in  DATA_W  burst trigger threshold (unsigned).
rd_addr  in  DEPTH_LOG2  buffer readback address.
adc_clk  out  1  ADC sample clock, combinational copy of clk.
sample  out  DATA_W  latest live or averaged sample.
sample_valid  out  1  one-cycle strobe when sample updates.
rd_data  out  DATA_W  buffer word at rd_addr.
capture_done  out  1  burst buffer full (level).
otr_count  out  16  count of cycles with OTR asserted, saturating.

Behaviour:
- Reset (async assert, sync release):
  - FSM = IDLE; sample = midscale (0x1FFF); sample_valid, capture_done, otr_count, accumulator, counters, write pointer = 0.
  - Buffer RAM contents are not reset.
- Input stage: adc_q <= adc_data and otr_q <= adc_otr every cycle. All logic uses adc_q (1 cycle of input latency). adc_p holds the previous adc_q.
- FSM states: IDLE, LIVE, AVG, ARM, CAPT, DONE.
- IDLE dispatch on control:
  - 0 -> LIVE.
  - 1 -> AVG, clearing accumulator and block count.
  - 2 -> ARM, clearing wr_ptr, capture_done and prev_valid.
  - 3 -> stay IDLE and clear otr_count that cycle.
  - Any other value -> stay IDLE.
- Mode exit: in LIVE/AVG/ARM/CAPT, if control != the state's code, go to IDLE next cycle. A partial average block or partial burst is discarded. A mode change therefore takes 2 cycles: exit to IDLE, then re-dispatch.
- LIVE: every cycle sample <= adc_q and sample_valid = 1.
- AVG:
  - Accumulator width is DATA_W+AVG_LOG2 and never overflows.
  - Each cycle acc += adc_q and cnt increments.
  - On the 2^AVG_LOG2-th sample: sample <= (acc+adc_q)>>AVG_LOG2 (truncating), sample_valid = 1 for one cycle, acc <= 0, cnt <= 0.
  - Output rate is one per 2^AVG_LOG2 cycles.
- ARM:
  - First cycle only sets prev_valid; no trigger is possible.
  - Trigger is a rising crossing: prev_valid && adc_p < trig_level && adc_q >= trig_level.
  - On trigger: mem[0] <= adc_q, wr_ptr <= 1, go to CAPT.
  - trig_level = 0 never triggers, because adc_p < 0 is impossible.
- CAPT:
  - Each cycle mem[wr_ptr] <= adc_q and wr_ptr increments.
  - On the write to DEPTH-1: go to DONE and capture_done <= 1.
  - Result is exactly DEPTH contiguous samples; address 0 holds the trigger sample.
- DONE:
  - No writes. capture_done stays 1.
  - Exit to IDLE when control != 2.
  - capture_done stays 1 after exit and clears only on the next entry into ARM or on reset.
  - Re-arming requires control to leave 2 and return.
- sample_valid is 0 in every case not listed above. sample holds its last value when not updating.
- Readback:
  - rd_data <= mem[rd_addr] with 1-cycle latency, in every state.
  - Buffer is a simple dual-port RAM (one write port, one read port); must infer block RAM.
  - A read of an address during the same cycle it is written returns the old content.
- otr_count increments on every cycle otr_q = 1 in any state, saturating at 0xFFFF. Clearing via control 3 has priority over incrementing.
- Reset asserted mid-capture: FSM returns to IDLE immediately. Buffer keeps partial data; capture_done reads 0.

Test Plan:
- Reset released, control = 0, adc_data ramps 0..9 -> sample tracks with 1 cycle of input latency plus 1 register, sample_valid high every cycle; before the first update, sample = 0x1FFF.
- control = 1, AVG_LOG2 = 4, adc_data alternating 100/101 -> one sample_valid every 16 cycles, sample = 100 (sum 1608 >> 4); constant 0x3FFF in -> sample = 0x3FFF.
- control = 2, trig_level = 0x2000, ramp through 0x1FFF then 0x2000 -> mem[0] = 0x2000 and mem[k] = 0x2000+k; capture_done rises exactly 1024 cycles after the trigger sample is registered; rd_addr = 5 gives rd_data = 0x2005 one cycle later.
- ARM with adc_data held at 0x3000 ≥ trig_level (no crossing) -> no trigger and capture_done stays 0; control switched 2 -> 0 mid-CAPT -> IDLE then LIVE, capture_done stays 0.
- adc_otr held high 70000 cycles -> otr_count = 0xFFFF; then control = 3 from IDLE -> otr_count = 0 next cycle.
- Assert rst_n low asynchronously mid-AVG -> outputs take reset values without a clock edge; after release, the first averaged sample covers a full 16 fresh samples.
